// File: rtl/ring_phase_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ring_phase_checker
//  Purpose  : Watches the 3-bit one-hot phase stream of the ring counter,
//             reports lock, completed rotations and faults, and counts
//             rotations (wrapping) and errors (saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module ring_phase_checker #(
  parameter int CNT_W  = 8,
  parameter int ERR_W  = 4,
  parameter int LOCK_N = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [2:0]       phase_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             fault,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             rot_pulse,
  output logic [CNT_W-1:0] rot_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  // Lock threshold fits in 4 bits (legal range 1..15).
  localparam logic [3:0] LOCK_C = 4'(LOCK_N);

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             prev_v_q, prev_v_d;
  logic [3:0]       prog_q, prog_d;
  logic             oh_q, oh_d;
  logic             seq_q, seq_d;
  logic             rot_q, rot_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic [ERR_W-1:0] ec_q, ec_d;

  logic             legal;
  logic [2:0]       exp_ph;
  logic             match;
  logic             mismatch;
  logic [ERR_W-1:0] ec_inc;

  // Next-state, counters and error-pulse decoding for the sampled phase.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
    prog_d   = prog_q;
    rc_d     = rc_q;
    ec_d     = ec_q;
    rot_d    = 1'b0;

    legal    = (phase_in == 3'b001) || (phase_in == 3'b010) || (phase_in == 3'b100);
    exp_ph   = {prev_q[1:0], prev_q[2]};
    match    = legal && prev_v_q && (phase_in == exp_ph);
    mismatch = legal && prev_v_q && (phase_in != exp_ph);
    ec_inc   = (ec_q == {ERR_W{1'b1}}) ? ec_q : ec_q + ERR_W'(1);

    // Error pulses are the same in every state; an illegal vector and a
    // bad rotation are mutually exclusive by construction.
    oh_d  = !legal;
    seq_d = mismatch;

    if (legal) begin
      prev_d   = phase_in;
      prev_v_d = 1'b1;
    end

    case (state_q)
      ST_SYNC: begin
        if (!legal) begin
          prog_d   = 4'd0;
          prev_v_d = 1'b0;
        end else if (match) begin
          prog_d = prog_q + 4'd1;
          if (prog_q + 4'd1 == LOCK_C) begin
            state_d = ST_LOCKED;
          end
        end else begin
          // First capture or a broken rotation: restart the lock count.
          prog_d = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (match) begin
          if (prev_q == 3'b100) begin
            rot_d = 1'b1;
            rc_d  = rc_q + CNT_W'(1);
          end
        end else begin
          ec_d    = ec_inc;
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (!legal || mismatch) begin
          ec_d = ec_inc;
        end
      end
      default: begin
        state_d  = ST_SYNC;
        prog_d   = 4'd0;
        prev_v_d = 1'b0;
      end
    endcase

    // Clear beats any error counted in the same cycle; only FAULT is exited.
    if (clr_err) begin
      ec_d = '0;
      if (state_q == ST_FAULT) begin
        state_d  = ST_SYNC;
        prog_d   = 4'd0;
        prev_v_d = 1'b0;
      end
    end
  end

  // State and output registers; reset discards the sample at its edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_SYNC;
      prev_q   <= 3'b000;
      prev_v_q <= 1'b0;
      prog_q   <= 4'd0;
      oh_q     <= 1'b0;
      seq_q    <= 1'b0;
      rot_q    <= 1'b0;
      rc_q     <= '0;
      ec_q     <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      prev_v_q <= prev_v_d;
      prog_q   <= prog_d;
      oh_q     <= oh_d;
      seq_q    <= seq_d;
      rot_q    <= rot_d;
      rc_q     <= rc_d;
      ec_q     <= ec_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign fault      = (state_q == ST_FAULT);
  assign onehot_err = oh_q;
  assign seq_err    = seq_q;
  assign rot_pulse  = rot_q;
  assign rot_count  = rc_q;
  assign err_count  = ec_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_phase_checker
//  Purpose  : Self-checking bench for ring_phase_checker: directed vector
//             table, wrap/saturation sequence and randomized stream against
//             an index-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_phase_checker;

  logic       Clock;
  logic       Reset;
  logic [2:0] phase_in;
  logic       clr_err;

  logic       locked_a, fault_a, oh_a, sq_a, rp_a;
  logic [7:0] rc_a;
  logic [3:0] ec_a;
  logic       locked_b, fault_b, oh_b, sq_b, rp_b;
  logic [1:0] rc_b;
  logic [1:0] ec_b;

  int total = 0;
  int bad   = 0;

  ring_phase_checker #(.CNT_W(8), .ERR_W(4), .LOCK_N(3)) dut_a (
    .Clock(Clock), .Reset(Reset), .phase_in(phase_in), .clr_err(clr_err),
    .locked(locked_a), .fault(fault_a), .onehot_err(oh_a), .seq_err(sq_a),
    .rot_pulse(rp_a), .rot_count(rc_a), .err_count(ec_a)
  );

  ring_phase_checker #(.CNT_W(2), .ERR_W(2), .LOCK_N(3)) dut_b (
    .Clock(Clock), .Reset(Reset), .phase_in(phase_in), .clr_err(clr_err),
    .locked(locked_b), .fault(fault_b), .onehot_err(oh_b), .seq_err(sq_b),
    .rot_pulse(rp_b), .rot_count(rc_b), .err_count(ec_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: phase tracked as a rotation index 0..2, mode 0/1/2 =
  // sync/locked/fault, counters as plain integers.
  typedef struct {
    int mode;
    int pidx;
    bit pv;
    int prog;
    int rc;
    int ec;
    bit oh;
    bit sq;
    bit rp;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit r, bit c, logic [2:0] ph, int cmod, int emax);
    mdl_t n;
    int   idx;
    bit   legal, good, bad_rot;
    n = m;
    n.oh = 0; n.sq = 0; n.rp = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    idx     = (ph == 3'b001) ? 0 : (ph == 3'b010) ? 1 : (ph == 3'b100) ? 2 : -1;
    legal   = (idx >= 0);
    good    = legal && m.pv && (idx == (m.pidx + 1) % 3);
    bad_rot = legal && m.pv && !good;
    n.oh = !legal;
    n.sq = bad_rot;
    if (legal) begin
      n.pidx = idx;
      n.pv   = 1;
    end
    if (m.mode == 0) begin
      if (!legal) begin
        n.prog = 0; n.pv = 0;
      end else if (good) begin
        n.prog = m.prog + 1;
        if (n.prog == 3) n.mode = 1;
      end else begin
        n.prog = 0;
      end
    end else if (m.mode == 1) begin
      if (good) begin
        if (m.pidx == 2) begin
          n.rp = 1;
          n.rc = (m.rc + 1) % cmod;
        end
      end else begin
        n.ec   = (m.ec < emax) ? m.ec + 1 : emax;
        n.mode = 2;
      end
    end else begin
      if (!legal || bad_rot) n.ec = (m.ec < emax) ? m.ec + 1 : emax;
    end
    if (c) begin
      n.ec = 0;
      if (m.mode == 2) begin
        n.mode = 0; n.prog = 0; n.pv = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] act_a();
    return {15'b0, locked_a, fault_a, oh_a, sq_a, rp_a, rc_a, ec_a};
  endfunction

  function automatic logic [31:0] act_b();
    return {23'b0, locked_b, fault_b, oh_b, sq_b, rp_b, rc_b, ec_b};
  endfunction

  function automatic logic [31:0] mpack_a(mdl_t m);
    return {15'b0, m.mode == 1, m.mode == 2, m.oh, m.sq, m.rp, 8'(m.rc), 4'(m.ec)};
  endfunction

  function automatic logic [31:0] mpack_b(mdl_t m);
    return {23'b0, m.mode == 1, m.mode == 2, m.oh, m.sq, m.rp, 2'(m.rc), 2'(m.ec)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one sample, let it be taken at the next edge, then advance models.
  task automatic step(bit r, bit c, logic [2:0] p);
    Reset    = r;
    clr_err  = c;
    phase_in = p;
    @(posedge Clock);
    #1;
    ma = mstep(ma, r, c, p, 256, 15);
    mb = mstep(mb, r, c, p, 4, 3);
  endtask

  // Directed vectors: flags are {locked, fault, onehot_err, seq_err, rot_pulse}.
  typedef struct {
    bit         rst;
    bit         clr;
    logic [2:0] ph;
    logic [4:0] fl;
    int         rc;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit r, bit c, logic [2:0] p, logic [4:0] f, int rc, int ec);
    vec_t v;
    v.rst = r; v.clr = c; v.ph = p; v.fl = f; v.rc = rc; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [2:0] p;
    bit         r, c;
    int         gi;

    Reset = 1'b1; clr_err = 1'b0; phase_in = 3'b001;
    ma = '{default: 0};
    mb = '{default: 0};

    // Clean lock and first rotation
    add(1, 0, 3'b001, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b00000, 0, 0);
    add(0, 0, 3'b010, 5'b00000, 0, 0);
    add(0, 0, 3'b100, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b10000, 0, 0);
    add(0, 0, 3'b010, 5'b10000, 0, 0);
    add(0, 0, 3'b100, 5'b10000, 0, 0);
    add(0, 0, 3'b001, 5'b10001, 1, 0);
    // Illegal vector while locked, then clear and relock
    add(0, 0, 3'b011, 5'b01100, 1, 1);
    add(0, 1, 3'b010, 5'b00000, 1, 0);
    add(0, 0, 3'b001, 5'b00000, 1, 0);
    add(0, 0, 3'b010, 5'b00000, 1, 0);
    add(0, 0, 3'b100, 5'b00000, 1, 0);
    add(0, 0, 3'b001, 5'b10000, 1, 0);
    // Sequence skip at 010, more errors, clear wins over a same-cycle error
    add(0, 0, 3'b010, 5'b10000, 1, 0);
    add(0, 0, 3'b001, 5'b01010, 1, 1);
    add(0, 0, 3'b000, 5'b01100, 1, 2);
    add(0, 0, 3'b111, 5'b01100, 1, 3);
    add(0, 1, 3'b000, 5'b00100, 1, 0);
    add(0, 0, 3'b001, 5'b00000, 1, 0);
    add(0, 0, 3'b010, 5'b00000, 1, 0);
    add(0, 0, 3'b100, 5'b00000, 1, 0);
    add(0, 0, 3'b001, 5'b10000, 1, 0);
    // Reset mid-fault discards the 001 sampled at the reset edge
    add(0, 0, 3'b010, 5'b10000, 1, 0);
    add(0, 0, 3'b111, 5'b01100, 1, 1);
    add(0, 0, 3'b000, 5'b01100, 1, 2);
    add(1, 0, 3'b001, 5'b00000, 0, 0);
    add(0, 0, 3'b010, 5'b00000, 0, 0);
    add(0, 0, 3'b100, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b00000, 0, 0);
    add(0, 0, 3'b010, 5'b10000, 0, 0);
    // Sync disturbance
    add(1, 0, 3'b000, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b00000, 0, 0);
    add(0, 0, 3'b010, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b00010, 0, 0);
    add(0, 0, 3'b010, 5'b00000, 0, 0);
    add(0, 0, 3'b100, 5'b00000, 0, 0);
    add(0, 0, 3'b001, 5'b10000, 0, 0);
    add(0, 0, 3'b010, 5'b10000, 0, 0);
    add(0, 0, 3'b100, 5'b10000, 0, 0);
    add(0, 0, 3'b001, 5'b10001, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].ph);
      chk($sformatf("vec%0d_a", i), act_a(), {15'b0, tbl[i].fl, 8'(tbl[i].rc), 4'(tbl[i].ec)});
      chk($sformatf("vec%0d_b", i), act_b(), {23'b0, tbl[i].fl, 2'(tbl[i].rc), 2'(tbl[i].ec)});
    end

    // Rotation wrap and error saturation on the narrow instance
    step(1, 0, 3'b001);
    step(0, 0, 3'b001);
    step(0, 0, 3'b010);
    step(0, 0, 3'b100);
    step(0, 0, 3'b001);
    chk("lock_before_wrap", {31'b0, locked_b}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 3'b010);
      step(0, 0, 3'b100);
      step(0, 0, 3'b001);
      chk($sformatf("wrap%0d_b", k), {29'b0, rp_b, rc_b}, {29'b0, 1'b1, 2'(k % 4)});
      chk($sformatf("wrap%0d_a", k), {23'b0, rp_a, rc_a}, {23'b0, 1'b1, 8'(k)});
    end
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 3'b000);
      chk($sformatf("sat%0d_b", k), {29'b0, fault_b, ec_b}, {29'b0, 1'b1, 2'((k < 3) ? k : 3)});
      chk($sformatf("sat%0d_a", k), {27'b0, fault_a, ec_a}, {27'b0, 1'b1, 4'(k)});
    end

    // Randomized mostly-clean stream with injected faults, clears and resets
    step(1, 0, 3'b001);
    gi = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        p = 3'($urandom_range(0, 7));
      end else begin
        gi = (gi + 1) % 3;
        p  = 3'b001 << gi;
      end
      step(r, c, p);
      chk("rnd_a", act_a(), mpack_a(ma));
      chk("rnd_b", act_b(), mpack_b(mb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
